// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, GF(2^8) helpers and the byte
// permutations used by the iterative cipher/decipher cores.
package aes_pkg;

  localparam int NR     = 10;
  localparam int KBUF_N = NR + 1;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_DEC  = 2'd2
  } fsm_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    gmul = p;
  endfunction

  // Column bytes are ordered top row first: c[31:24] is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    inv_mix_col[31:24] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
    inv_mix_col[23:16] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
    inv_mix_col[15:8]  = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
    inv_mix_col[7:0]   = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    inv_mix_columns = o;
  endfunction

  // Byte n = 4*col + row; row r is rotated right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    inv_shift_rows = o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational table lookup for the decrypt datapath.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign d = TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational table lookup (used by key expansion).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset 8*(255-a) of the packed table.
  assign d = TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: expands the key into an 11-entry round-key
// buffer, then runs one inverse round per clock.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         key_rdy,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         done,
  output logic         busy,
  output logic [127:0] text_out
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rcnt_q, rcnt_d;
  state_t       state_q, state_d;
  state_t       text_out_q, text_out_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         key_rdy_q, key_rdy_d;
  state_t       rk_q [KBUF_N];

  logic         rk_we_s;
  logic [3:0]   rk_widx_s;
  state_t       rk_wdata_s;

  state_t       rk_prev_s;
  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  state_t       rk_next_s;

  state_t       isr_s;
  state_t       isb_s;
  state_t       ark_s;
  state_t       imc_s;

  // Key schedule step: derive round key rcnt from round key rcnt-1.
  assign rk_prev_s = rk_q[rcnt_q - 4'd1];
  assign rot_s     = rot_word(rk_prev_s[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_ksbox
    aes_sbox u_sbox (.a(rot_s[8*i +: 8]), .d(sub_s[8*i +: 8]));
  end

  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_s ^ {rcon(rcnt_q), 24'h000000};
    w0 = rk_prev_s[127:96] ^ t;
    w1 = rk_prev_s[95:64]  ^ w0;
    w2 = rk_prev_s[63:32]  ^ w1;
    w3 = rk_prev_s[31:0]   ^ w2;
    rk_next_s = {w0, w1, w2, w3};
  end

  // One inverse round; the final round takes ark_s and skips InvMixColumns.
  assign isr_s = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_isbox
    aes_inv_sbox u_isbox (.a(isr_s[8*i +: 8]), .d(isb_s[8*i +: 8]));
  end

  assign ark_s = isb_s ^ rk_q[rcnt_q];
  assign imc_s = inv_mix_columns(ark_s);

  // Next-state and output logic for the IDLE/KEXP/DEC controller.
  always_comb begin
    fsm_d      = fsm_q;
    rcnt_d     = rcnt_q;
    state_d    = state_q;
    text_out_d = text_out_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    key_rdy_d  = key_rdy_q;
    rk_we_s    = 1'b0;
    rk_widx_s  = rcnt_q;
    rk_wdata_s = rk_next_s;
    case (fsm_q)
      ST_IDLE: begin
        if (kld) begin
          rk_we_s    = 1'b1;
          rk_widx_s  = 4'd0;
          rk_wdata_s = key;
          rcnt_d     = 4'd1;
          busy_d     = 1'b1;
          key_rdy_d  = 1'b0;
          fsm_d      = ST_KEXP;
        end else if (ld && key_rdy_q) begin
          state_d = text_in ^ rk_q[NR];
          rcnt_d  = 4'd9;
          busy_d  = 1'b1;
          fsm_d   = ST_DEC;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_KEXP: begin
        rk_we_s = 1'b1;
        if (kld) begin
          rk_widx_s  = 4'd0;
          rk_wdata_s = key;
          rcnt_d     = 4'd1;
        end else if (rcnt_q == 4'd10) begin
          key_rdy_d = 1'b1;
          busy_d    = 1'b0;
          rcnt_d    = 4'd0;
          fsm_d     = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      ST_DEC: begin
        if (rcnt_q == 4'd0) begin
          text_out_d = ark_s;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          fsm_d      = ST_IDLE;
        end else begin
          state_d = imc_s;
          rcnt_d  = rcnt_q - 4'd1;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        busy_d = 1'b0;
        rcnt_d = 4'd0;
      end
    endcase
  end

  // State, output and round-key buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= ST_IDLE;
      rcnt_q     <= 4'd0;
      state_q    <= 128'h0;
      text_out_q <= 128'h0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      key_rdy_q  <= 1'b0;
      for (int i = 0; i < KBUF_N; i++) begin
        rk_q[i] <= 128'h0;
      end
    end else begin
      fsm_q      <= fsm_d;
      rcnt_q     <= rcnt_d;
      state_q    <= state_d;
      text_out_q <= text_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      key_rdy_q  <= key_rdy_d;
      for (int i = 0; i < KBUF_N; i++) begin
        if (rk_we_s && (rk_widx_s == 4'(i))) begin
          rk_q[i] <= rk_wdata_s;
        end
      end
    end
  end

  assign key_rdy  = key_rdy_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 / SP800-38A vectors,
// back-to-back timing, protocol abuse and mid-decrypt reset.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         kld = 1'b0;
  logic [127:0] key = 128'h0;
  logic         key_rdy;
  logic         ld = 1'b0;
  logic [127:0] text_in = 128'h0;
  logic         done;
  logic         busy;
  logic [127:0] text_out;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT_2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_3   = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PT_3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT_4   = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] PT_4   = 128'hf69f2445df4f9b17ad2b417be66c3710;

  aes_inv_cipher_iter dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .key      (key),
    .key_rdy  (key_rdy),
    .ld       (ld),
    .text_in  (text_in),
    .done     (done),
    .busy     (busy),
    .text_out (text_out)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all are entered and left just after a negedge.
  task automatic load_key(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    @(negedge clk);
    kld = 1'b0;
  endtask

  task automatic start_ld(input logic [127:0] ct);
    ld      = 1'b1;
    text_in = ct;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_key(input int max_cyc, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = (key_rdy === 1'b1);
    end
    if (!seen) n = -1;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = (done === 1'b1);
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({key_rdy, done, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000", {key_rdy, done, busy});
    end
    tests_run++;
    if (text_out !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_text_out: got %h want 0", text_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_key;
    int done_cnt, busy_cnt;
    done_cnt = 0;
    busy_cnt = 0;
    start_ld(CT_B);
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      tests_failed++;
      $display("FAIL no_key_ld: got done=%0d busy=%0d cycles want 0/0", done_cnt, busy_cnt);
    end
  endtask

  task automatic test_fips_b;
    int n;
    load_key(KEY_B);
    tests_run++;
    if (busy !== 1'b1 || key_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL kexp_flags: got busy=%b key_rdy=%b want 1/0", busy, key_rdy);
    end
    wait_key(20, n);
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL kexp_latency: got %0d want 10", n);
    end
    tests_run++;
    if (dut.rk_q[10] !== RK10_B) begin
      tests_failed++;
      $display("FAIL rk10_b: got %h want %h", dut.rk_q[10], RK10_B);
    end
    start_ld(CT_B);
    wait_done(20, n);
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL dec_latency_b: got %0d want 10", n);
    end
    tests_run++;
    if (text_out !== PT_B) begin
      tests_failed++;
      $display("FAIL fips_b_pt: got %h want %h", text_out, PT_B);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_fips_c1;
    int n;
    load_key(KEY_C);
    wait_key(20, n);
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL kexp_latency_c: got %0d want 10", n);
    end
    start_ld(CT_C);
    wait_done(20, n);
    tests_run++;
    if (n !== 10 || text_out !== PT_C) begin
      tests_failed++;
      $display("FAIL fips_c1: got n=%0d pt=%h want n=10 pt=%h", n, text_out, PT_C);
    end
  endtask

  task automatic test_back_to_back;
    int  n;
    bit  held;
    bit  seen;
    load_key(KEY_B);
    wait_key(20, n);
    start_ld(CT_1);
    wait_done(20, n);
    tests_run++;
    if (text_out !== PT_1) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h want %h", text_out, PT_1);
    end
    start_ld(CT_2);
    n    = 1;
    held = 1'b1;
    seen = 1'b0;
    while (!seen && n < 25) begin
      if (text_out !== PT_1) held = 1'b0;
      @(negedge clk);
      n++;
      seen = (done === 1'b1);
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL b2b_hold: got changed text_out want held %h", PT_1);
    end
    tests_run++;
    if (n !== 11) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d want 11", n);
    end
    tests_run++;
    if (text_out !== PT_2) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h want %h", text_out, PT_2);
    end
  endtask

  task automatic test_abuse_mid_dec;
    int n;
    start_ld(CT_3);
    repeat (3) @(negedge clk);
    ld      = 1'b1;
    text_in = CT_4;
    kld     = 1'b1;
    key     = KEY_C;
    @(negedge clk);
    ld  = 1'b0;
    kld = 1'b0;
    wait_done(20, n);
    tests_run++;
    if (n !== 6 || text_out !== PT_3) begin
      tests_failed++;
      $display("FAIL mid_dec_ignore: got n=%0d pt=%h want n=6 pt=%h", n, text_out, PT_3);
    end
    tests_run++;
    if (key_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_dec_key_rdy: got %b want 1", key_rdy);
    end
    start_ld(CT_4);
    wait_done(20, n);
    tests_run++;
    if (n !== 10 || text_out !== PT_4) begin
      tests_failed++;
      $display("FAIL key_kept: got n=%0d pt=%h want n=10 pt=%h", n, text_out, PT_4);
    end
  endtask

  task automatic test_kld_ld_same;
    int n;
    int done_cnt;
    kld     = 1'b1;
    key     = KEY_C;
    ld      = 1'b1;
    text_in = CT_B;
    @(negedge clk);
    kld = 1'b0;
    tests_run++;
    if (key_rdy !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL kld_wins: got key_rdy=%b busy=%b want 0/1", key_rdy, busy);
    end
    done_cnt = 0;
    // ld held one more cycle lands inside KEXP and must be dropped too.
    @(negedge clk);
    ld = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (done_cnt !== 0 || key_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL kld_ld_no_dec: got done=%0d key_rdy=%b want 0/1", done_cnt, key_rdy);
    end
    start_ld(CT_C);
    wait_done(20, n);
    tests_run++;
    if (text_out !== PT_C) begin
      tests_failed++;
      $display("FAIL reloaded_key: got %h want %h", text_out, PT_C);
    end
  endtask

  task automatic test_reset_mid_dec;
    int n;
    int done_cnt;
    start_ld(CT_C);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({key_rdy, busy, done} !== 3'b000 || text_out !== 128'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got flags=%b pt=%h want 000/0", {key_rdy, busy, done}, text_out);
    end
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (done_cnt !== 0 || key_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: got done=%0d key_rdy=%b want 0/0", done_cnt, key_rdy);
    end
    load_key(KEY_B);
    wait_key(20, n);
    start_ld(CT_B);
    wait_done(20, n);
    tests_run++;
    if (n !== 10 || text_out !== PT_B) begin
      tests_failed++;
      $display("FAIL after_reset_b: got n=%0d pt=%h want n=10 pt=%h", n, text_out, PT_B);
    end
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_fips_b();
    test_fips_c1();
    test_back_to_back();
    test_abuse_mid_dec();
    test_kld_ld_same();
    test_reset_mid_dec();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
